alu_module: RTL and testbench
=============================

ALU_MODULE -- requirements
Module: alu_module

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port num1, input, 32 bits: operand A, two's complement.
REQ-004 SHALL have port num2, input, 32 bits: operand B, two's complement.
REQ-005 SHALL have port alu_ctrl, input, 6 bits: operation select.
REQ-006 SHALL have port res, output, 32 bits: registered result.
REQ-007 SHALL have port zero, output, 1 bit: registered flag, 1 when res is all-zero.

Function
REQ-008 SHALL sample num1, num2 and alu_ctrl on each rising clk edge with rst low, and present the result on res one cycle later (latency 1, throughput 1 per cycle, no handshake).
REQ-009 SHALL decode alu_ctrl as follows: 0 ADD num1+num2; 1 SUB num1-num2; 2 AND; 3 OR; 4 XOR; 5 NOR.
REQ-010 SHALL decode alu_ctrl as follows: 6 SLT, res=1 if num1<num2 signed else 0; 7 SLTU, unsigned compare.
REQ-011 SHALL decode alu_ctrl as follows: 8 SLL num1<<num2[4:0]; 9 SRL, logical shift right; 10 SRA, arithmetic shift right; only num2[4:0] is used as the shift amount.
REQ-012 SHALL decode alu_ctrl as follows: 11 MIN, signed minimum (fuzzy AND); 12 MAX, signed maximum (fuzzy OR); 13 fuzzy NOT, res=~num1.
REQ-013 SHALL decode alu_ctrl as follows: 14 MUL, lower 32 bits of num1*num2; 15 LUI, {num2[15:0],16'h0000}.
REQ-014 SHALL drive res to 0 for every alu_ctrl value 16-63 (reserved).
REQ-015 SHALL wrap ADD, SUB and MUL modulo 2^32, with no overflow or carry output.
REQ-016 SHALL register zero in the same cycle as res, computed from the new result, so zero==(res==0) holds on every cycle.
REQ-017 SHALL handle equal operands as follows: SLT=0, MIN=MAX=that value.
REQ-018 SHALL handle shift amount 0 as res=num1 for SLL, SRL and SRA.

Reset
REQ-019 SHALL, on a clk edge with rst high, set res to 0 and zero to 1, regardless of the inputs.
REQ-020 SHALL discard the operation sampled in a cycle where rst is high; the first valid result appears one cycle after rst deasserts.
REQ-021 SHALL give rst priority over any operation, including when rst is asserted mid-stream.

Structure
REQ-022 SHALL place the opcode constants (ALU_ADD to ALU_LUI) and the data width (32) in a shared package alu_pkg, used by both the control decoder and the bench.
REQ-023 SHALL implement the shift unit as one sub-module, alu_shifter, with combinational SLL/SRL/SRA selected by a 2-bit mode; all other operations SHALL be inline combinational logic feeding one output register stage.

Verification
REQ-024 SHALL cover shifts: num1=-9 (0xFFFFFFF7), num2=3 -> ctrl 9 gives res 0x1FFFFFFE; ctrl 10 gives 0xFFFFFFFE; ctrl 8 gives 0xFFFFFFB8; zero=0 in each case.
REQ-025 SHALL cover MIN/MAX: num1=-9, num2=3 -> ctrl 11 gives 0xFFFFFFF7; ctrl 12 gives 0x00000003.
REQ-026 SHALL cover logic and compare: num1=-9, num2=3 -> ctrl 4 gives 0xFFFFFFF4; ctrl 5 gives 0x00000008; ctrl 6 gives 1; ctrl 7 gives 0.
REQ-027 SHALL cover arithmetic and zero: num1=-9, num2=3 -> ctrl 0 gives 0xFFFFFFFA and ctrl 1 gives 0xFFFFFFF4; num1=num2=5, ctrl 1 -> res 0, zero=1; num1=0x7FFFFFFF, num2=1, ctrl 0 -> res 0x80000000 (wrap).
REQ-028 SHALL cover reset and latency: drive ctrl 12 with rst high -> next cycle res=0, zero=1; deassert rst -> res=3 exactly one cycle later; ctrl 40 -> res 0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU slice: data width, opcode constants for the
// alu_ctrl decoder, the shift-unit mode encoding and a small zero-test helper.
// Imported by alu_shifter, alu_module and the bench so that every user agrees
// on the opcode map.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 6;
  localparam int SHAMT_W = $clog2(DATA_W);

  // Opcode map for alu_ctrl; every value from 16 up to 63 is reserved.
  localparam logic [CTRL_W-1:0] ALU_ADD  = 6'd0;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 6'd1;
  localparam logic [CTRL_W-1:0] ALU_AND  = 6'd2;
  localparam logic [CTRL_W-1:0] ALU_OR   = 6'd3;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 6'd4;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 6'd5;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 6'd6;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 6'd7;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 6'd8;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 6'd9;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 6'd10;
  localparam logic [CTRL_W-1:0] ALU_MIN  = 6'd11;
  localparam logic [CTRL_W-1:0] ALU_MAX  = 6'd12;
  localparam logic [CTRL_W-1:0] ALU_NOT  = 6'd13;
  localparam logic [CTRL_W-1:0] ALU_MUL  = 6'd14;
  localparam logic [CTRL_W-1:0] ALU_LUI  = 6'd15;

  // Shift unit mode; SHIFT_PASS returns the operand unchanged when no
  // shift opcode is selected.
  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'd0,
    SHIFT_SRL  = 2'd1,
    SHIFT_SRA  = 2'd2,
    SHIFT_PASS = 2'd3
  } shift_mode_e;

  // True when every bit of the word is clear.
  function automatic logic is_zero(input logic [DATA_W-1:0] value);
    return (value == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational barrel shifter used by the ALU for SLL, SRL and SRA.
// Ports:
//   data   - operand to shift (DATA_W bits)
//   shamt  - shift amount, 0..DATA_W-1
//   mode   - SHIFT_SLL / SHIFT_SRL / SHIFT_SRA / SHIFT_PASS
//   result - shifted value (DATA_W bits)
// -----------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_mode_e        mode,
  output logic [DATA_W-1:0]  result
);

  // Select the shift flavour; SRA replicates the sign bit via a signed shift.
  always_comb begin
    result = data;
    case (mode)
      SHIFT_SLL:  result = data << shamt;
      SHIFT_SRL:  result = data >> shamt;
      SHIFT_SRA:  result = $unsigned($signed(data) >>> shamt);
      SHIFT_PASS: result = data;
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/alu_module.sv
// -----------------------------------------------------------------------------
// alu_module
// Single-stage registered ALU. Operands and opcode are sampled on every rising
// clk edge and the result appears on res one cycle later; zero is registered
// alongside res so it always describes the value currently on res.
// Ports:
//   clk      - clock, all state on the rising edge
//   rst      - synchronous active-high reset (res=0, zero=1), beats any op
//   num1     - operand A, two's complement
//   num2     - operand B, two's complement
//   alu_ctrl - operation select (see alu_pkg), 16..63 reserved -> res=0
//   res      - registered result
//   zero     - registered flag, 1 when res is all-zero
// -----------------------------------------------------------------------------
module alu_module
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  input  logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] res,
  output logic              zero
);

  shift_mode_e       shift_mode_s;
  logic [DATA_W-1:0] shift_result_s;
  logic              lt_signed_s;
  logic              lt_unsigned_s;
  logic [DATA_W-1:0] mul_s;
  logic [DATA_W-1:0] result_s;
  logic [DATA_W-1:0] res_r;
  logic              zero_r;

  // Shared comparators: SLT/SLTU use them directly, MIN/MAX pick an operand.
  assign lt_signed_s   = ($signed(num1) < $signed(num2));
  assign lt_unsigned_s = (num1 < num2);

  // Lower word of the product; the upper half is intentionally dropped.
  assign mul_s = num1 * num2;

  // Map the shift opcodes onto the shifter mode; everything else passes.
  always_comb begin
    shift_mode_s = SHIFT_PASS;
    case (alu_ctrl)
      ALU_SLL: shift_mode_s = SHIFT_SLL;
      ALU_SRL: shift_mode_s = SHIFT_SRL;
      ALU_SRA: shift_mode_s = SHIFT_SRA;
      default: shift_mode_s = SHIFT_PASS;
    endcase
  end

  alu_shifter u_shifter (
    .data   (num1),
    .shamt  (num2[SHAMT_W-1:0]),
    .mode   (shift_mode_s),
    .result (shift_result_s)
  );

  // Next-result mux; reserved opcodes fall through to zero.
  always_comb begin
    result_s = {DATA_W{1'b0}};
    case (alu_ctrl)
      ALU_ADD:  result_s = num1 + num2;
      ALU_SUB:  result_s = num1 - num2;
      ALU_AND:  result_s = num1 & num2;
      ALU_OR:   result_s = num1 | num2;
      ALU_XOR:  result_s = num1 ^ num2;
      ALU_NOR:  result_s = ~(num1 | num2);
      ALU_SLT:  result_s = {{(DATA_W-1){1'b0}}, lt_signed_s};
      ALU_SLTU: result_s = {{(DATA_W-1){1'b0}}, lt_unsigned_s};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  result_s = shift_result_s;
      ALU_MIN:  result_s = lt_signed_s ? num1 : num2;
      ALU_MAX:  result_s = lt_signed_s ? num2 : num1;
      ALU_NOT:  result_s = ~num1;
      ALU_MUL:  result_s = mul_s;
      ALU_LUI:  result_s = {num2[15:0], 16'h0000};
      default:  result_s = {DATA_W{1'b0}};
    endcase
  end

  // Output register stage; zero is derived from the same next value as res.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_r  <= {DATA_W{1'b0}};
      zero_r <= 1'b1;
    end else begin
      res_r  <= result_s;
      zero_r <= is_zero(result_s);
    end
  end

  assign res  = res_r;
  assign zero = zero_r;

endmodule

// File: tb/tb_alu_module.sv
// -----------------------------------------------------------------------------
// tb_alu_module
// Self-checking bench for alu_module: a table of directed vectors, hand-written
// reset/latency sequences and a randomized stream compared against a plain
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_module;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [5:0]  alu_ctrl;
  logic [31:0] res;
  logic        zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_module dut (
    .clk      (clk),
    .rst      (rst),
    .num1     (num1),
    .num2     (num2),
    .alu_ctrl (alu_ctrl),
    .res      (res),
    .zero     (zero)
  );

  // Reference model built from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] op);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    int     sh = int'(b % 32'd32);
    longint p  = longint'(64'd1) << sh;
    longint q;
    case (op)
      6'd0:  return 32'(ua + ub);
      6'd1:  return 32'(ua - ub);
      6'd2:  return a & b;
      6'd3:  return a | b;
      6'd4:  return a ^ b;
      6'd5:  return ~(a | b);
      6'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      6'd7:  return (ua < ub) ? 32'd1 : 32'd0;
      6'd8:  return 32'(ua * p);
      6'd9:  return 32'(ua / p);
      6'd10: begin
        q = (sa < 0) ? -((-sa + p - 1) / p) : (sa / p);
        return 32'(q);
      end
      6'd11: return (sa <= sb) ? a : b;
      6'd12: return (sa >= sb) ? a : b;
      6'd13: return ~a;
      6'd14: return 32'(ua * ub);
      6'd15: return 32'(ub % 65536 * 65536);
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] op);
    @(negedge clk);
    rst      = r;
    num1     = a;
    num2     = b;
    alu_ctrl = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] exp_res, input logic exp_zero);
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s: res=%h expected %h", name, res, exp_res);
    end
    checks++;
    if (zero !== exp_zero) begin
      errors++;
      $display("FAIL %s: zero=%b expected %b", name, zero, exp_zero);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rop;
    logic        rr;
    logic [31:0] er;

    rst = 1'b1; num1 = 32'd0; num2 = 32'd0; alu_ctrl = 6'd0;

    vecs.push_back('{"srl_m9",   32'hFFFFFFF7, 32'd3, ALU_SRL,  32'h1FFFFFFE, 1'b0});
    vecs.push_back('{"sra_m9",   32'hFFFFFFF7, 32'd3, ALU_SRA,  32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"sll_m9",   32'hFFFFFFF7, 32'd3, ALU_SLL,  32'hFFFFFFB8, 1'b0});
    vecs.push_back('{"min_m9",   32'hFFFFFFF7, 32'd3, ALU_MIN,  32'hFFFFFFF7, 1'b0});
    vecs.push_back('{"max_m9",   32'hFFFFFFF7, 32'd3, ALU_MAX,  32'h00000003, 1'b0});
    vecs.push_back('{"xor_m9",   32'hFFFFFFF7, 32'd3, ALU_XOR,  32'hFFFFFFF4, 1'b0});
    vecs.push_back('{"nor_m9",   32'hFFFFFFF7, 32'd3, ALU_NOR,  32'h00000008, 1'b0});
    vecs.push_back('{"slt_m9",   32'hFFFFFFF7, 32'd3, ALU_SLT,  32'h00000001, 1'b0});
    vecs.push_back('{"sltu_m9",  32'hFFFFFFF7, 32'd3, ALU_SLTU, 32'h00000000, 1'b1});
    vecs.push_back('{"add_m9",   32'hFFFFFFF7, 32'd3, ALU_ADD,  32'hFFFFFFFA, 1'b0});
    vecs.push_back('{"sub_m9",   32'hFFFFFFF7, 32'd3, ALU_SUB,  32'hFFFFFFF4, 1'b0});
    vecs.push_back('{"sub_eq",   32'd5, 32'd5, ALU_SUB,  32'h00000000, 1'b1});
    vecs.push_back('{"add_wrap", 32'h7FFFFFFF, 32'd1, ALU_ADD, 32'h80000000, 1'b0});
    vecs.push_back('{"and",      32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND, 32'h00F000F0, 1'b0});
    vecs.push_back('{"or",       32'hF0F0F0F0, 32'h0FF00FF0, ALU_OR,  32'hFFF0FFF0, 1'b0});
    vecs.push_back('{"slt_eq",   32'd5, 32'd5, ALU_SLT, 32'h00000000, 1'b1});
    vecs.push_back('{"min_eq",   32'hFFFFFFFB, 32'hFFFFFFFB, ALU_MIN, 32'hFFFFFFFB, 1'b0});
    vecs.push_back('{"max_eq",   32'hFFFFFFFB, 32'hFFFFFFFB, ALU_MAX, 32'hFFFFFFFB, 1'b0});
    vecs.push_back('{"sltu_t",   32'd3, 32'hFFFFFFF7, ALU_SLTU, 32'h00000001, 1'b0});
    vecs.push_back('{"sll_0",    32'h12345678, 32'h00000020, ALU_SLL, 32'h12345678, 1'b0});
    vecs.push_back('{"srl_0",    32'h80000001, 32'h00000000, ALU_SRL, 32'h80000001, 1'b0});
    vecs.push_back('{"sra_0",    32'h80000000, 32'h00000000, ALU_SRA, 32'h80000000, 1'b0});
    vecs.push_back('{"srl_31",   32'h80000000, 32'd31, ALU_SRL, 32'h00000001, 1'b0});
    vecs.push_back('{"sra_31",   32'h80000000, 32'd31, ALU_SRA, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"not",      32'h0F0F0F0F, 32'd0, ALU_NOT, 32'hF0F0F0F0, 1'b0});
    vecs.push_back('{"not_ones", 32'hFFFFFFFF, 32'd7, ALU_NOT, 32'h00000000, 1'b1});
    vecs.push_back('{"mul",      32'hFFFFFFFF, 32'd2, ALU_MUL, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"mul_wrap", 32'h00010000, 32'h00010000, ALU_MUL, 32'h00000000, 1'b1});
    vecs.push_back('{"lui",      32'h11111111, 32'hABCD1234, ALU_LUI, 32'h12340000, 1'b0});
    vecs.push_back('{"rsv_16",   32'hFFFFFFF7, 32'd3, 6'd16, 32'h00000000, 1'b1});
    vecs.push_back('{"rsv_63",   32'h12345678, 32'h9ABCDEF0, 6'd63, 32'h00000000, 1'b1});

    // Reset state after two reset cycles.
    step(1'b1, 32'hFFFFFFF7, 32'd3, ALU_ADD);
    step(1'b1, 32'hFFFFFFF7, 32'd3, ALU_ADD);
    check("reset_state", 32'd0, 1'b1);

    // Directed table, applied back to back.
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].op);
      check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_zero);
    end

    // Reset discards the sampled op; first result one cycle after release.
    step(1'b1, 32'hFFFFFFF7, 32'd3, ALU_MAX);
    check("rst_discard", 32'd0, 1'b1);
    step(1'b0, 32'hFFFFFFF7, 32'd3, ALU_MAX);
    check("rst_release", 32'd3, 1'b0);
    step(1'b0, 32'hFFFFFFF7, 32'd3, 6'd40);
    check("rsv_40", 32'd0, 1'b1);

    // Reset asserted mid-stream between two valid operations.
    step(1'b0, 32'd5, 32'd7, ALU_ADD);
    check("pre_mid_rst", 32'd12, 1'b0);
    step(1'b1, 32'd5, 32'd7, ALU_ADD);
    check("mid_rst", 32'd0, 1'b1);
    step(1'b0, 32'd5, 32'd7, ALU_SUB);
    check("post_mid_rst", 32'hFFFFFFFE, 1'b0);

    // Randomized stream against the reference model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rop = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(16, 63))
                                         : 6'($urandom_range(0, 15));
      rr  = ($urandom_range(0, 31) == 0);
      step(rr, ra, rb, rop);
      er = rr ? 32'd0 : model(ra, rb, rop);
      check($sformatf("rand%0d_op%0d", i, rop), er, (er == 32'd0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
